ram_burst_ctrl: RTL and testbench
=================================

Name: ram_burst_ctrl

Overview:
- Burst front-end that sits directly upstream of the team's 256x32 single-port RAM.
- Accepts one read or write burst command at a time and converts it into per-beat RAM accesses: mem_rd_en/mem_wr_en/mem_addr/mem_wdata.
- Write data comes in on a valid/ready stream. Read data goes out on a valid/ready stream with full backpressure support.
- Absorbs the RAM's 1-cycle registered read latency with a 2-entry output buffer.

Parameters:
- ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 32, data width.
- LEN_W, 8, width of cmd_len; burst beats = cmd_len+1, so 1..2^LEN_W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  LEN_W  beats minus one.
- wdata_valid  in  1  write beat offered.
- wdata_ready  out  1  write beat accepted.
- wdata  in  DATA_W  write beat data.
- rdata_valid  out  1  read beat available.
- rdata_ready  in  1  consumer accepts read beat.
- rdata  out  DATA_W  read beat data.
- rdata_last  out  1  marks final beat of read burst.
- mem_rd_en  out  1  RAM read strobe.
- mem_wr_en  out  1  RAM write strobe.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after mem_rd_en.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse on burst completion.

Behaviour:
- States: IDLE, WRITE, READ.
- Reset: synchronous on a rising edge with rst=1.
  - State goes to IDLE; beat counter, address and in-flight flag are cleared; buffer is emptied.
  - rdata_valid=0, rdata_last=0, done=0, busy=0, mem_rd_en=0, mem_wr_en=0, rdata=0.
  - cmd_ready and wdata_ready are forced 0 while rst=1.
- Reset mid-burst aborts immediately. A RAM read in flight at the reset edge is discarded. No done pulse is generated.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch cmd_addr and cmd_len.
  - Go to WRITE if cmd_write=1, else READ.
  - cmd_ready=0 outside IDLE; one burst outstanding at most.
- WRITE:
  - wdata_ready=1.
  - mem_wr_en = wdata_valid & wdata_ready, combinational and same cycle.
  - mem_addr = current address; mem_wdata = wdata.
  - Each accepted beat increments the address (wrapping 0xFF->0x00) and decrements the remaining count.
  - Accepting the final beat returns to IDLE next cycle.
  - wdata_ready=0 in IDLE/READ; stray wdata is not consumed.
- READ issue:
  - mem_rd_en=1 when beats remain to issue and (buffer_count + inflight - pop) < 2.
  - pop = rdata_valid & rdata_ready.
  - mem_addr = issue address, which increments with wrap on each issue.
  - mem_rd_en and mem_wr_en are never high together.
- READ capture and output:
  - mem_rdata is captured into the buffer the cycle after mem_rd_en.
  - rdata/rdata_valid come from the buffer head, so the first beat is valid 3 cycles after the command handshake.
  - With rdata_ready held high, throughput is 1 beat/cycle.
  - rdata and rdata_last must stay stable while rdata_valid=1 and rdata_ready=0.
  - Beats are delivered strictly in address order. rdata_last=1 only on beat cmd_len+1.
  - After the last beat is popped, the block returns to IDLE next cycle.
- done:
  - Registered; high for exactly one cycle, the cycle after the final write handshake or final read pop.
  - Coincides with the first cycle of IDLE, so cmd_ready=1 in the same cycle.
  - A new command may be accepted in that cycle.
- busy = (state != IDLE).
- Counters are LEN_W+1 bits wide, so cmd_len=2^LEN_W-1 (256 beats) works. A full-length burst starting anywhere wraps and touches every address once.

Test Plan:
- Write burst 4 beats:
  - Stimulus: cmd_write=1, addr=0x10, len=3; wdata 0xA0..0xA3 back-to-back.
  - Required: mem_wr_en on 4 consecutive cycles at addr 0x10..0x13; done pulses 1 cycle after the 4th handshake.
- Read-back:
  - Stimulus: cmd_write=0, addr=0x10, len=3, rdata_ready=1.
  - Required: rdata 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles, first 3 cycles after the handshake; rdata_last only on 0xA3.
- Wrap:
  - Stimulus: write then read, addr=0xFE, len=3.
  - Required: mem_addr sequence 0xFE,0xFF,0x00,0x01; data returned in that order.
- Backpressure:
  - Stimulus: 8-beat read with rdata_ready toggling 1,0,0,1,...
  - Required: no beat lost or duplicated; rdata stable while stalled; outstanding reads never exceed 2.
- Reset mid-burst:
  - Stimulus: assert rst for 1 cycle during beat 3 of an 8-beat read.
  - Required: next cycle busy=0, rdata_valid=0, no done pulse, cmd_ready=1 once rst=0; a following 1-beat read returns correct data.
- Max length:
  - Stimulus: write len=255 at addr 0x80, then read len=255.
  - Required: 256 beats each way; every address written exactly once; done once per burst.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// Burst front-end for the 256x32 single-port RAM.
// Turns one read/write burst command into per-beat RAM strobes. Write beats
// stream straight through to the RAM. Read beats land in a 2-entry buffer,
// which hides the RAM's 1-cycle read latency and lets the consumer stall.
module ram_burst_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  state_t state, state_n;

  // Beats still to be accepted (write) or issued (read); one bit wider than
  // cmd_len so a full 2^LEN_W burst is representable.
  logic [LEN_W:0]  beats_left;
  logic [ADDR_W-1:0] addr;

  // RAM read issued last cycle; its data appears on mem_rdata this cycle.
  logic inflight;
  logic inflight_last;

  // 2-entry read return buffer.
  logic [1:0][DATA_W-1:0] fifo_data;
  logic [1:0]             fifo_last;
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             fifo_cnt;

  logic       pop;
  logic [2:0] occ;
  logic       burst_end;

  assign rdata_valid = (fifo_cnt != 2'd0);
  assign rdata       = fifo_data[rd_ptr];
  assign rdata_last  = fifo_last[rd_ptr] & rdata_valid;
  assign pop         = rdata_valid & rdata_ready;

  // Slots that will be committed once this cycle's pop retires.
  assign occ = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);

  assign mem_wr_en = wdata_valid & wdata_ready;
  assign mem_addr  = addr;
  assign mem_wdata = wdata;
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, handshakes and read issue.
  always_comb begin
    state_n     = state;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    mem_rd_en   = 1'b0;
    burst_end   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid && !rst) state_n = cmd_write ? WRITE : READ;
      end
      WRITE: begin
        wdata_ready = ~rst;
        if (wdata_valid && !rst && beats_left == CNT_ONE) begin
          burst_end = 1'b1;
          state_n   = IDLE;
        end
      end
      READ: begin
        mem_rd_en = ~rst && (beats_left != '0) && (occ < 3'd2);
        if (pop && rdata_last) begin
          burst_end = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Address/count tracking, read capture buffer and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr          <= '0;
      beats_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_data     <= '0;
      fifo_last     <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_cnt      <= 2'd0;
      done          <= 1'b0;
    end else begin
      done <= burst_end;
      if (cmd_valid && cmd_ready) begin
        addr       <= cmd_addr;
        beats_left <= {1'b0, cmd_len} + CNT_ONE;
      end else if (mem_wr_en || mem_rd_en) begin
        addr       <= addr + ADDR_W'(1);
        beats_left <= beats_left - CNT_ONE;
      end
      inflight      <= mem_rd_en;
      inflight_last <= mem_rd_en && (beats_left == CNT_ONE);
      if (inflight) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl with a behavioural 256x32 RAM.
module tb_ram_burst_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_ready;
  logic          wdata_valid = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          wdata_ready;
  logic          rdata_valid, rdata_last;
  logic          rdata_ready = 1'b1;
  logic [DW-1:0] rdata;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy, done;

  ram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM model: registered read.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; logic last; } rbeat_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic last; } wbeat_t;

  rbeat_t        rq[$];
  logic [AW-1:0] raq[$];
  wbeat_t        wq[$];
  int            dq[$];
  logic [DW-1:0] shadow [256];
  int            hits [256];

  int n_cmp = 0, n_fail = 0;

  // Stimulus-owned request flags read by the monitor.
  bit chk_idle = 0, chk_hits = 0, clr_hits = 0, chk_end = 0, chk_tp = 0;
  int tmo_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor state.
  int     tmo_seen = 0, hs_cyc = 0, last_pop_cyc = 0, pop_total = 0;
  int     issued = 0, popped = 0, bad;
  bit     first_pending = 0, first_beat = 0, prev_stall = 0, pop_now;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  rbeat_t        re;
  wbeat_t        we;
  logic [AW-1:0] ea;
  int            ed;

  always @(negedge clk) begin
    if (tmo_cnt != tmo_seen) begin
      chk("timeout", 64'(tmo_cnt), 64'(tmo_seen));
      tmo_seen = tmo_cnt;
    end
    if (clr_hits) for (int a = 0; a < 256; a++) hits[a] = 0;
    if (rst) begin
      rq.delete(); raq.delete(); wq.delete(); dq.delete();
      issued = 0; popped = 0;
      prev_stall = 0; first_pending = 0; first_beat = 0;
    end else begin
      pop_now = rdata_valid && rdata_ready;
      if (cmd_valid && cmd_ready && !cmd_write) begin
        hs_cyc = cyc; first_pending = 1; first_beat = 1;
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(rdata_valid), 64'(1));
        chk("stall_data", 64'({rdata_last, rdata}), 64'({prev_last, prev_data}));
      end
      prev_stall = rdata_valid && !rdata_ready;
      prev_data  = rdata;
      prev_last  = rdata_last;
      if (rdata_valid && first_pending) begin
        chk("rd_latency", 64'(cyc - hs_cyc), 64'(3));
        first_pending = 0;
      end
      if (pop_now) begin
        if (rq.size() == 0) chk("rd_unexpected", 64'(1), 64'(0));
        else begin
          re = rq.pop_front();
          chk("rdata", 64'(rdata), 64'(re.data));
          chk("rdata_last", 64'(rdata_last), 64'(re.last));
          if (chk_tp && !first_beat) chk("rd_tput", 64'(cyc - last_pop_cyc), 64'(1));
          if (re.last) dq.push_back(cyc + 1);
        end
        first_beat = 0;
        last_pop_cyc = cyc;
        pop_total++;
      end
      if (mem_wr_en) begin
        hits[mem_addr]++;
        if (wq.size() == 0) chk("wr_unexpected", 64'(1), 64'(0));
        else begin
          we = wq.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(we.addr));
          chk("wr_data", 64'(mem_wdata), 64'(we.data));
          if (we.last) dq.push_back(cyc + 1);
        end
      end
      if (mem_rd_en) begin
        chk("rd_wr_excl", 64'(mem_wr_en), 64'(0));
        chk("outstanding_le2", 64'(issued - popped - int'(pop_now) + 1 <= 2), 64'(1));
        if (raq.size() == 0) chk("rd_issue_unexpected", 64'(1), 64'(0));
        else begin
          ea = raq.pop_front();
          chk("rd_addr", 64'(mem_addr), 64'(ea));
        end
        issued++;
      end
      if (pop_now) popped++;
      if (done) begin
        if (dq.size() == 0) chk("done_unexpected", 64'(1), 64'(0));
        else begin
          ed = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(ed));
        end
        chk("done_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("done_busy", 64'(busy), 64'(0));
      end
    end
    if (chk_idle) begin
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_rvalid", 64'(rdata_valid), 64'(0));
      chk("idle_rlast", 64'(rdata_last), 64'(0));
      chk("idle_rdata", 64'(rdata), 64'(0));
      chk("idle_done", 64'(done), 64'(0));
      chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("idle_wdata_ready", 64'(wdata_ready), 64'(0));
      chk("idle_mem_en", 64'({mem_rd_en, mem_wr_en}), 64'(0));
    end
    if (chk_hits) begin
      bad = 0;
      for (int a = 0; a < 256; a++) if (hits[a] != 1) bad++;
      chk("every_addr_written_once", 64'(bad), 64'(0));
    end
    if (chk_end) begin
      chk("end_rq_empty", 64'(rq.size()), 64'(0));
      chk("end_wq_empty", 64'(wq.size()), 64'(0));
      chk("end_raq_empty", 64'(raq.size()), 64'(0));
      chk("end_dq_empty", 64'(dq.size()), 64'(0));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_hs();
    bit ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) tmo_cnt++;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) tmo_cnt++;
    tick();
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [DW-1:0] base);
    logic [AW-1:0] a;
    bit ok;
    for (int i = 0; i <= len; i++) begin
      a = AW'(int'(addr) + i);
      shadow[a] = base + DW'(i);
      wq.push_back('{a, base + DW'(i), i == len});
    end
    cmd_write = 1'b1; cmd_addr = addr; cmd_len = LW'(len); cmd_valid = 1'b1;
    wait_hs();
    for (int i = 0; i <= len; i++) begin
      wdata_valid = 1'b1; wdata = base + DW'(i);
      ok = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (wdata_ready) begin ok = 1; break; end
      end
      if (!ok) tmo_cnt++;
      tick();
    end
    wdata_valid = 1'b0;
    wait_idle();
  endtask

  // Pushes read expectations and issues the command; mode 0 = ready held
  // high, mode 1 = ready pattern 1,0,0 repeating.
  task automatic start_read(input logic [AW-1:0] addr, input int len, input int mode);
    logic [AW-1:0] a;
    for (int i = 0; i <= len; i++) begin
      a = AW'(int'(addr) + i);
      raq.push_back(a);
      rq.push_back('{shadow[a], i == len});
    end
    chk_tp = (mode == 0);
    rdata_ready = 1'b1;
    cmd_write = 1'b0; cmd_addr = addr; cmd_len = LW'(len); cmd_valid = 1'b1;
    wait_hs();
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int len, input int mode);
    bit ok = 0;
    start_read(addr, len, mode);
    for (int k = 0; k < 2000; k++) begin
      rdata_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
      tick();
    end
    if (!ok) tmo_cnt++;
    rdata_ready = 1'b1;
    tick();
  endtask

  initial begin
    int base_pops;
    bit ok;
    repeat (3) tick();
    rst = 1'b0; chk_idle = 1;
    tick();
    chk_idle = 0;

    // 4-beat write then read-back at 0x10.
    do_write(8'h10, 3, 32'hA0);
    do_read(8'h10, 3, 0);

    // Address wrap through 0xFF.
    do_write(8'hFE, 3, 32'hC0);
    do_read(8'hFE, 3, 0);

    // Backpressure on an 8-beat read.
    do_write(8'h40, 7, 32'hB0);
    do_read(8'h40, 7, 1);

    // Reset during beat 3 of an 8-beat read.
    base_pops = pop_total;
    start_read(8'h40, 7, 0);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      if (pop_total >= base_pops + 2) begin ok = 1; break; end
    end
    if (!ok) tmo_cnt++;
    #1 rst = 1'b1;
    tick();
    rst = 1'b0; chk_idle = 1;
    tick();
    chk_idle = 0;
    repeat (3) tick();
    do_read(8'h40, 0, 0);

    // Full-length bursts.
    clr_hits = 1; tick(); clr_hits = 0;
    do_write(8'h80, 255, 32'h5A00_0000);
    chk_hits = 1; tick(); chk_hits = 0;
    do_read(8'h80, 255, 0);

    repeat (4) tick();
    chk_end = 1; tick(); chk_end = 0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 200000", cyc);
    $fatal(1, "watchdog");
  end

endmodule
